// File: rtl/cpu_flag_stack.sv
// CPU condition-flag register with masked ALU update, bus access and a
// circular save/restore stack that reports overflow and underflow stickily.
module cpu_flag_stack #(
    parameter int FLAG_W = 4,
    parameter int BUS_W  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              CLK_I,
    input  logic              nRST_I,
    input  logic              UPD_I,
    input  logic [FLAG_W-1:0] MASK_I,
    input  logic [FLAG_W-1:0] FLAG_I,
    input  logic              WR_I,
    input  logic [BUS_W-1:0]  BUS_I,
    input  logic              RD_I,
    input  logic              PUSH_I,
    input  logic              POP_I,
    input  logic              CLR_I,
    output logic [FLAG_W-1:0] FLAG_O,
    output logic [BUS_W-1:0]  BUS_O,
    output logic [PTR_W-1:0]  SP_O,
    output logic [PTR_W:0]    CNT_O,
    output logic              OVF_O,
    output logic              UDF_O
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W:0] CNT_FULL = {1'b1, {PTR_W{1'b0}}};

    logic [FLAG_W-1:0] flags, flags_next;
    logic [FLAG_W-1:0] stack [DEPTH];
    logic [PTR_W-1:0]  sp, sp_m1, sp_next;
    logic [PTR_W:0]    cnt, cnt_next;
    logic              ovf, ovf_next, udf, udf_next;
    logic              push_only, pop_only, xchg, is_full, is_empty;
    logic [BUS_W-1:0]  bus_ext;
    logic              unused_bus;

    assign push_only  = PUSH_I & ~POP_I;
    assign pop_only   = POP_I & ~PUSH_I;
    assign xchg       = PUSH_I & POP_I;
    assign is_full    = (cnt == CNT_FULL);
    assign is_empty   = (cnt == '0);
    assign sp_m1      = sp - PTR_W'(1);
    assign unused_bus = ^BUS_I;

    // Pop (alone or as half of an exchange) outranks bus write, which outranks ALU update
    always_comb begin
        flags_next = flags;
        if (POP_I) begin
            flags_next = stack[sp_m1];
        end else if (WR_I) begin
            flags_next = BUS_I[FLAG_W-1:0];
        end else if (UPD_I) begin
            flags_next = (flags & ~MASK_I) | (FLAG_I & MASK_I);
        end
    end

    always_comb begin
        sp_next  = sp;
        cnt_next = cnt;
        ovf_next = ovf;
        udf_next = udf;
        if (push_only) begin
            sp_next = sp + PTR_W'(1);
            if (!is_full) begin
                cnt_next = cnt + (PTR_W + 1)'(1);
            end
        end else if (pop_only) begin
            sp_next = sp_m1;
            if (!is_empty) begin
                cnt_next = cnt - (PTR_W + 1)'(1);
            end
        end
        // A new error event wins over a same-cycle clear
        if (CLR_I) begin
            ovf_next = 1'b0;
            udf_next = 1'b0;
        end
        if (push_only && is_full) begin
            ovf_next = 1'b1;
        end
        if (POP_I && is_empty) begin
            udf_next = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            flags <= '0;
            sp    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            flags <= flags_next;
            sp    <= sp_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            udf   <= udf_next;
        end
    end

    // Stack storage is deliberately not reset; pushes always store the pre-edge flags
    always_ff @(posedge CLK_I) begin
        if (nRST_I) begin
            if (push_only) begin
                stack[sp] <= flags;
            end else if (xchg) begin
                stack[sp_m1] <= flags;
            end
        end
    end

    always_comb begin
        bus_ext = '0;
        bus_ext[FLAG_W-1:0] = flags;
        BUS_O = RD_I ? bus_ext : '0;
    end

    assign FLAG_O = flags;
    assign SP_O   = sp;
    assign CNT_O  = cnt;
    assign OVF_O  = ovf;
    assign UDF_O  = udf;

endmodule

// File: tb/tb_cpu_flag_stack.sv
// Self-checking bench for cpu_flag_stack: table-driven vectors fed through a
// scoreboard queue, plus hand-written overflow, bus-timing and async-reset sequences.
module tb_cpu_flag_stack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       upd, wr, rd, push, pop, clr;
    logic [3:0] mask, flg;
    logic [7:0] bus_in;
    logic [3:0] flag_out;
    logic [7:0] bus_out;
    logic [2:0] sp_out;
    logic [3:0] cnt_out;
    logic       ovf_out, udf_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       upd;
        logic [3:0] mask;
        logic [3:0] flg;
        logic       wr;
        logic [7:0] bus;
        logic       rd;
        logic       push;
        logic       pop;
        logic       clr;
        logic       chk;
        logic [3:0] e_flags;
        logic [2:0] e_sp;
        logic [3:0] e_cnt;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cpu_flag_stack #(.FLAG_W(4), .BUS_W(8), .PTR_W(3)) dut (
        .CLK_I(clk), .nRST_I(rst_n), .UPD_I(upd), .MASK_I(mask), .FLAG_I(flg),
        .WR_I(wr), .BUS_I(bus_in), .RD_I(rd), .PUSH_I(push), .POP_I(pop),
        .CLR_I(clr), .FLAG_O(flag_out), .BUS_O(bus_out), .SP_O(sp_out),
        .CNT_O(cnt_out), .OVF_O(ovf_out), .UDF_O(udf_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic u, logic [3:0] m, logic [3:0] f, logic w, logic [7:0] b,
                                logic r, logic pu, logic po, logic c, logic ck,
                                logic [3:0] ef, logic [2:0] es, logic [3:0] ec, logic eo, logic eu);
        vec_t v;
        v.upd = u; v.mask = m; v.flg = f; v.wr = w; v.bus = b; v.rd = r;
        v.push = pu; v.pop = po; v.clr = c; v.chk = ck; v.e_flags = ef;
        v.e_sp = es; v.e_cnt = ec; v.e_ovf = eo; v.e_udf = eu;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        upd = 0; mask = 0; flg = 0; wr = 0; bus_in = 0; rd = 0; push = 0; pop = 0; clr = 0;
    endtask

    task automatic check_output(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            compare({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.chk) begin
                compare({tag, " flags"}, 32'(flag_out), 32'(e.e_flags));
                compare({tag, " bus"}, 32'(bus_out), e.rd ? 32'(e.e_flags) : 32'd0);
            end else if (!e.rd) begin
                compare({tag, " bus idle"}, 32'(bus_out), 32'd0);
            end
            compare({tag, " sp"}, 32'(sp_out), 32'(e.e_sp));
            compare({tag, " cnt"}, 32'(cnt_out), 32'(e.e_cnt));
            compare({tag, " ovf"}, 32'(ovf_out), 32'(e.e_ovf));
            compare({tag, " udf"}, 32'(udf_out), 32'(e.e_udf));
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        upd = v.upd; mask = v.mask; flg = v.flg; wr = v.wr; bus_in = v.bus;
        rd = v.rd; push = v.push; pop = v.pop; clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        rd = 1'b1;
        #1;
        compare("reset bus", 32'(bus_out), 32'h00);
        compare("reset flags", 32'(flag_out), 32'h0);
        compare("reset cnt", 32'(cnt_out), 32'h0);
        compare("reset sp", 32'(sp_out), 32'h0);
        compare("reset ovf/udf", 32'({ovf_out, udf_out}), 32'h0);

        // masked update, write priority, LIFO, underflow, exchange
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h0A, 0, 0, 0, 0, 1, 4'hA, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 4'h5, 0, 8'h00, 0, 0, 0, 0, 1, 4'h9, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, 1, 8'hF6, 0, 0, 0, 0, 1, 4'h6, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 4'hF, 0, 8'h00, 1, 0, 0, 0, 1, 4'h6, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h01, 0, 0, 0, 0, 1, 4'h1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h02, 0, 1, 0, 0, 1, 4'h2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h03, 0, 1, 0, 0, 1, 4'h3, 2, 2, 0, 0));
        tbl.push_back(mk(1, 4'hF, 4'h0, 0, 8'h00, 0, 1, 0, 0, 1, 4'h0, 3, 3, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 4'h3, 2, 2, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h0F, 0, 0, 1, 0, 1, 4'h2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 4'h1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 7, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 7, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 6, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h0C, 0, 0, 0, 1, 1, 4'hC, 6, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 0, 0, 1, 4'hC, 7, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 8'h03, 0, 0, 0, 0, 1, 4'h3, 7, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 1, 1, 1, 0, 1, 4'hC, 7, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 1, 0, 1, 4'h3, 6, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 1, 0, 0, 4'h0, 6, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 4'h3, 5, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 1, 1, 4'h3, 5, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // BUS_O reflects the register, not a same-cycle write
        drive_idle();
        rd = 1'b1; wr = 1'b1; bus_in = 8'h09;
        #1;
        compare("bus before write edge", 32'(bus_out), 32'h03);
        @(posedge clk);
        #1;
        compare("bus after write edge", 32'(bus_out), 32'h09);

        // overflow wrap: push 0..8 into an 8-deep stack, then pop 8 times
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            apply_stimulus(mk(0, 4'h0, 4'h0, 1, 8'(i), 0, 0, 0, 0, 1, 4'(i), 3'(i),
                              (i > 8) ? 4'd8 : 4'(i), 0, 0), $sformatf("ovf_wr%0d", i));
            apply_stimulus(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 0, 0, 1, 4'(i), 3'(i + 1),
                              (i + 1 > 8) ? 4'd8 : 4'(i + 1), (i == 8), 0),
                           $sformatf("ovf_push%0d", i));
        end
        for (int j = 0; j < 8; j++) begin
            apply_stimulus(mk(0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 4'(8 - j), 3'(8 - j),
                              4'(7 - j), 1, 0), $sformatf("ovf_pop%0d", j));
        end
        apply_stimulus(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 1, 1, 4'h1, 1, 0, 0, 0), "ovf_clr");

        // asynchronous reset in the middle of a push
        apply_stimulus(mk(0, 4'h0, 4'h0, 1, 8'h05, 0, 0, 0, 0, 1, 4'h5, 1, 0, 0, 0), "ar_wr");
        apply_stimulus(mk(0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 0, 0, 1, 4'h5, 2, 1, 0, 0), "ar_push");
        drive_idle();
        push = 1'b1; rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        compare("async reset flags", 32'(flag_out), 32'h0);
        compare("async reset bus", 32'(bus_out), 32'h00);
        compare("async reset sp", 32'(sp_out), 32'h0);
        compare("async reset cnt", 32'(cnt_out), 32'h0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_flag_stack.md
Name: cpu_flag_stack

Overview:
Parametrised successor to the CPU status register for the MCS-8 core. It holds FLAG_W condition flags and supports masked per-flag ALU updates, bus write and bus read. It adds a circular save/restore stack of flag states with sticky overflow and underflow indication, used by interrupt entry/exit and extended call/return. It sits between the ALU, the internal data bus and the instruction decoder/sequencer.

Parameters:
FLAG_W, 4, number of flags. Default bit order: [3]=CF, [2]=PF, [1]=ZF, [0]=SF. Legal range 1..BUS_W.
BUS_W, 8, internal data bus width.
PTR_W, 3, stack pointer width. Stack depth DEPTH = 2**PTR_W; PTR_W >= 1.

Ports:
CLK_I  in  1  single system clock; all state changes on the rising edge.
nRST_I  in  1  asynchronous, active-low reset.
UPD_I  in  1  ALU flag update strobe.
MASK_I  in  FLAG_W  per-flag update enable; bit=1 means the flag takes FLAG_I.
FLAG_I  in  FLAG_W  new flag values from the ALU.
WR_I  in  1  load the flags from BUS_I[FLAG_W-1:0].
BUS_I  in  BUS_W  internal data bus in.
RD_I  in  1  drive the flags onto BUS_O.
PUSH_I  in  1  save the current flags to the stack.
POP_I  in  1  restore the flags from the stack.
CLR_I  in  1  clear OVF_O and UDF_O.
FLAG_O  out  FLAG_W  current flag register.
BUS_O  out  BUS_W  {zeros, flags} when RD_I=1, else all zeros (wired-OR bus convention).
SP_O  out  PTR_W  stack pointer: index of the next free slot.
CNT_O  out  PTR_W+1  number of valid entries, 0..DEPTH.
OVF_O  out  1  sticky: a push occurred while the stack was full.
UDF_O  out  1  sticky: a pop occurred while the stack was empty.

Behaviour:
- Reset (nRST_I=0, asynchronous): flags=0, SP=0, CNT=0, OVF=0, UDF=0. Stack RAM contents are not reset and are don't-care. All control inputs are ignored while reset is asserted.
- BUS_O is combinational from the current flags and RD_I. It does not reflect same-cycle writes.
- All register updates take effect one cycle after the strobe, visible on FLAG_O after the edge.

Flag register next-value priority, highest first:
- POP_I (with or without PUSH_I): flags <= stack[SP-1 mod DEPTH].
- WR_I: flags <= BUS_I[FLAG_W-1:0].
- UPD_I: flags <= (flags & ~MASK_I) | (FLAG_I & MASK_I). MASK_I=0 leaves the flags unchanged.
- Otherwise: hold.

Stack operations:
- PUSH only: stack[SP] <= flags. The value written is the pre-edge flags, not same-cycle UPD/WR data. SP <= SP+1 mod DEPTH. CNT <= CNT+1, saturating at DEPTH.
  - If CNT==DEPTH: the oldest entry is overwritten (circular), CNT stays DEPTH, OVF <= 1.
- POP only: flags load from stack[SP-1]. SP <= SP-1 mod DEPTH. CNT <= CNT-1.
  - If CNT==0: flags still load the stale entry at SP-1, SP still decrements, CNT stays 0, UDF <= 1.
- PUSH and POP in the same cycle: exchange. Flags <= stack[SP-1] and stack[SP-1] <= pre-edge flags. SP and CNT are unchanged.
  - If CNT==0: the exchange still occurs and UDF <= 1.
- WR_I or UPD_I in the same cycle as PUSH: the push stores the old flags. Flag register priority applies as above (POP wins over WR/UPD).

Sticky flags:
- CLR_I clears OVF and UDF.
- If CLR_I coincides with a new error event, the set wins (flag ends at 1).

Implementation constraints:
- No combinational path from stack RAM to BUS_O other than through the flag register.
- Stack implemented as DEPTH x FLAG_W registers.
- SP wrap is pure modulo 2**PTR_W arithmetic.

Test Plan:
- Reset then RD_I=1 -> BUS_O=8'h00, FLAG_O=0, CNT_O=0. Assert nRST_I=0 mid-PUSH -> all outputs 0 immediately, without waiting for a clock edge.
- Masked update: flags=4'b1010, UPD_I=1, MASK_I=4'b0011, FLAG_I=4'b0101 -> FLAG_O=4'b1001 next cycle. Same cycle WR_I=1, BUS_I=8'hF6 -> FLAG_O=4'b0110 (WR wins over UPD).
- Push/pop LIFO: push flags 1,2,3 (SP_O=3, CNT_O=3), then pop three times -> FLAG_O sequence 3,2,1, CNT_O=0, OVF_O=UDF_O=0.
- Overflow wrap (DEPTH=8): push 9 values 0..8 -> CNT_O=8, SP_O=1, OVF_O=1. Pop 8 times -> sequence 8,7,6,5,4,3,2,1; the value 0 was overwritten.
- Underflow: from reset, POP_I -> UDF_O=1, CNT_O=0, SP_O=7. CLR_I with no event -> UDF_O=0. CLR_I together with another empty pop -> UDF_O stays 1.
- Exchange: stack top=4'hC, flags=4'h3, PUSH_I=POP_I=1 -> FLAG_O=4'hC, a following POP returns 4'h3, and SP_O/CNT_O are unchanged during the exchange cycle.
